countdown_timer: RTL

Synchronous loadable down-counter: the counterpart of the free-running up-count timer. Software or a controller FSM loads a start value, enables counting with `start`, and the block decrements at a prescaled rate until zero. It then raises a one-cycle `expired` pulse and holds a sticky `done` flag. It sits beside the up-count timer in the clock/timing subsystem and drives timeouts and alarm events.

---
 rtl/countdown_timer.sv | 89 ++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with a one-cycle expiry pulse and a sticky done flag.
// States: IDLE (idle/zero), RUN (counting), HOLD (paused), DONE (expired, awaiting ack or load).
module countdown_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             ack,
  output logic [WIDTH-1:0] timer_time,
  output logic             running,
  output logic             expired,
  output logic             done
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] time_nx;
  logic [PW-1:0]    presc, presc_nx;
  logic             exp_nx;
  logic             tick;

  assign tick = (state == RUN) && (presc == PS_MAX);

  always_comb begin
    state_nx = state;
    time_nx  = timer_time;
    presc_nx = presc;
    exp_nx   = 1'b0;
    if (load) begin
      time_nx  = load_value;
      presc_nx = '0;
      state_nx = (load_value != '0 && start) ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: if (start && timer_time != '0) begin
          state_nx = RUN;
          presc_nx = '0;
        end
        RUN: begin
          // A tick's decrement lands even when start drops on the same edge.
          if (tick) begin
            presc_nx = '0;
            time_nx  = timer_time - 1'b1;
            if (timer_time == WIDTH'(1)) begin
              state_nx = DONE;
              exp_nx   = 1'b1;
            end else if (!start) begin
              state_nx = HOLD;
            end
          end else if (!start) begin
            state_nx = HOLD;
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
        HOLD: if (start) state_nx = RUN;
        DONE: begin
          time_nx = '0;
          if (ack) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer_time <= '0;
      presc      <= '0;
      expired    <= 1'b0;
    end else begin
      state      <= state_nx;
      timer_time <= time_nx;
      presc      <= presc_nx;
      expired    <= exp_nx;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);
endmodule
